// File: rtl/cpu_pkg.sv
// Shared CPU definitions: control-flow opcodes, the canonical NOP and the
// fetch queue entry format used by the fetch stage.
package cpu_pkg;

    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [31:0] NOP_INST  = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry;

    typedef enum logic {
        FS_BOOT,
        FS_RUN
    } fetch_state_e;

    function automatic logic is_ctrl_op(input logic [6:0] op);
        return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetched {pc, inst} pairs that absorbs responses while
// decode is stalled. Clear wins over push/pop in the same cycle.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int QDEPTH = 2,
    parameter int CW     = $clog2(QDEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  fetch_entry    entry_i,
    input  logic          pop_i,
    input  logic          clear_i,
    output logic [CW-1:0] count_o,
    output logic          empty_o,
    output fetch_entry    head_o
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_pop;
    fetch_entry    mem_q [QDEPTH];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop  = pop_i && (count_q != '0);
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rptr_q];

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clear_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) wptr_d = ptr_inc(wptr_q);
            if (do_pop) rptr_d = ptr_inc(rptr_q);
            case ({push_i, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; count_q alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push_i && !clear_i) mem_q[wptr_q] <= entry_i;
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && !clear_i && (count_q == FULL_CNT)));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, keeps up to QDEPTH requests plus
// buffered words in flight, and loads the IF/ID register read by decode.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int          QDEPTH   = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        prediction,
    input  logic [31:0] new_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        valid
);

    localparam int CW = $clog2(QDEPTH + 1);
    localparam logic [CW:0] CREDITS = (CW + 1)'(QDEPTH);

    fetch_state_e  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [31:0]   if_pc_q, if_pc_d;
    logic [31:0]   if_inst_q, if_inst_d;
    logic          if_valid_q, if_valid_d;

    logic [CW-1:0] q_count;
    logic          q_empty;
    fetch_entry    q_head;
    fetch_entry    resp_entry;
    logic          q_push, q_pop;
    logic          dec_redirect, flush, fire, resp_keep, load, bypass;
    logic [31:0]   target;

    assign dec_redirect = if_valid_q && !stall && prediction && is_ctrl_op(if_inst_q[6:0]);
    assign flush        = redirect || dec_redirect;
    assign target       = (redirect ? redirect_pc : new_pc) & 32'hFFFF_FFFC;

    // Credits cover both in-flight requests and buffered words, so a
    // response can always be accepted without backpressure.
    assign imem_req  = (state_q == FS_RUN) && !flush &&
                       (({1'b0, outst_q} + {1'b0, q_count}) < CREDITS);
    assign imem_addr = fetch_pc_q;

    assign fire       = imem_req && imem_gnt;
    assign resp_keep  = imem_rvalid && (discard_q == '0);
    assign load       = !stall && !flush;
    assign bypass     = load && q_empty && resp_keep;
    assign q_pop      = load && !q_empty;
    assign q_push     = resp_keep && !flush && !bypass;
    assign resp_entry = '{pc: resp_pc_q, inst: imem_rdata};

    assign pc    = if_pc_q;
    assign inst  = if_inst_q;
    assign valid = if_valid_q;

    fetch_queue #(
        .QDEPTH (QDEPTH),
        .CW     (CW)
    ) u_queue (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (q_push),
        .entry_i (resp_entry),
        .pop_i   (q_pop),
        .clear_i (flush),
        .count_o (q_count),
        .empty_o (q_empty),
        .head_o  (q_head)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            FS_BOOT: state_d = FS_RUN;
            FS_RUN:  state_d = FS_RUN;
            default: state_d = FS_BOOT;
        endcase
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        outst_d    = outst_q + CW'(fire) - CW'(imem_rvalid);
        discard_d  = discard_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        if_valid_d = if_valid_q;

        if (fire)                                 fetch_pc_d = fetch_pc_q + 32'd4;
        if (resp_keep)                            resp_pc_d  = resp_pc_q + 32'd4;
        if (imem_rvalid && (discard_q != '0))     discard_d  = discard_q - CW'(1);

        // Every response still owed (minus one arriving now) belongs to the
        // abandoned path; fire is low here so outst only loses rvalid.
        if (flush) begin
            fetch_pc_d = target;
            resp_pc_d  = target;
            discard_d  = outst_q - CW'(imem_rvalid);
            if_valid_d = 1'b0;
            if_inst_d  = NOP_INST;
        end else if (load) begin
            if (q_pop) begin
                if_pc_d    = q_head.pc;
                if_inst_d  = q_head.inst;
                if_valid_d = 1'b1;
            end else if (bypass) begin
                if_pc_d    = resp_pc_q;
                if_inst_d  = imem_rdata;
                if_valid_d = 1'b1;
            end else begin
                if_valid_d = 1'b0;
                if_inst_d  = NOP_INST;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= FS_BOOT;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
            if_pc_q    <= RESET_PC;
            if_inst_q  <= NOP_INST;
            if_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
            if_valid_q <= if_valid_d;
        end
    end

    a_credit: assert property (@(posedge clk) disable iff (!rst)
        (discard_q <= outst_q) && ({1'b0, outst_q} <= CREDITS) && ({1'b0, q_count} <= CREDITS));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order instruction memory whose
// responses can be held back to build up outstanding requests.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        prediction;
    logic [31:0] new_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;

    logic        hold;
    logic [31:0] pend [$];
    int          nvec;
    int          nmis;

    fetch_unit #(
        .QDEPTH   (2),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .prediction  (prediction),
        .new_pc      (new_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc          (pc),
        .inst        (inst),
        .valid       (valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Words are addr<<7 | 0x13 (an ALU op), except two planted jal words.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h18 || a == 32'h108) return 32'h0000_006F;
        return (a << 7) | 32'h13;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend.delete();
            imem_rvalid <= 1'b0;
            imem_rdata  <= 32'h0;
        end else begin
            if (imem_req && imem_gnt) pend.push_back(imem_addr);
            imem_rvalid <= 1'b0;
            if (!hold && pend.size() > 0) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= mem_word(pend[0]);
                void'(pend.pop_front());
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nvec = 0; nmis = 0;
        rst = 1'b1; imem_gnt = 1'b1; hold = 1'b0;
        stall = 1'b0; prediction = 1'b0; new_pc = 32'h0;
        redirect = 1'b0; redirect_pc = 32'h0;
        #2 rst = 1'b0;
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_inst", inst, 32'h13);
        chk("rst_valid", {31'b0, valid}, 32'h0);
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;

        step(); chk("boot_req", {31'b0, imem_req}, 32'h1); chk("boot_addr0", imem_addr, 32'h0);
        chk("boot_novalid", {31'b0, valid}, 32'h0);
        step(); chk("boot_addr4", imem_addr, 32'h4); chk("boot_novalid2", {31'b0, valid}, 32'h0);
        step(); chk("run_pc0", pc, 32'h0); chk("run_v0", {31'b0, valid}, 32'h1);
        chk("run_inst0", inst, 32'h13); chk("run_addr8", imem_addr, 32'h8);
        step(); chk("run_pc4", pc, 32'h4);
        step(); chk("run_pc8", pc, 32'h8); chk("run_inst8", inst, 32'h413);

        stall = 1'b1;
        #1 chk("stall_req0", {31'b0, imem_req}, 32'h1); chk("stall_addr10", imem_addr, 32'h10);
        step(); chk("stall_pc_a", pc, 32'h8); chk("stall_req_a", {31'b0, imem_req}, 32'h0);
        step(); chk("stall_pc_b", pc, 32'h8); chk("stall_req_b", {31'b0, imem_req}, 32'h0);
        step(); chk("stall_pc_c", pc, 32'h8); chk("stall_vld_c", {31'b0, valid}, 32'h1);
        stall = 1'b0;
        #1 chk("unstall_req", {31'b0, imem_req}, 32'h0);
        step(); chk("drain_pcC", pc, 32'hC); chk("drain_instC", inst, 32'h613);
        chk("drain_addr14", imem_addr, 32'h14);
        step(); chk("drain_pc10", pc, 32'h10); chk("drain_inst10", inst, 32'h813);
        step(); chk("drain_pc14", pc, 32'h14); chk("drain_v14", {31'b0, valid}, 32'h1);

        hold = 1'b1;
        step(); chk("jal_pc", pc, 32'h18); chk("jal_inst", inst, 32'h6F);
        prediction = 1'b1; new_pc = 32'h100; hold = 1'b0;
        #1 chk("dec_flush_req", {31'b0, imem_req}, 32'h0);
        step(); prediction = 1'b0;
        #1 chk("dec_bubble_v", {31'b0, valid}, 32'h0); chk("dec_bubble_inst", inst, 32'h13);
        chk("dec_req", {31'b0, imem_req}, 32'h1); chk("dec_addr", imem_addr, 32'h100);
        step(); chk("dec_drop_v", {31'b0, valid}, 32'h0);
        step(); chk("dec_tgt_pc", pc, 32'h100); chk("dec_tgt_v", {31'b0, valid}, 32'h1);
        chk("dec_tgt_inst", inst, 32'h8013);
        step(); chk("seq_pc104", pc, 32'h104);

        step(); chk("jal2_pc", pc, 32'h108); chk("jal2_inst", inst, 32'h6F);
        prediction = 1'b1; new_pc = 32'h100; redirect = 1'b1; redirect_pc = 32'h200;
        #1 chk("prio_req", {31'b0, imem_req}, 32'h0);
        step(); prediction = 1'b0; redirect = 1'b0;
        #1 chk("prio_bubble", {31'b0, valid}, 32'h0); chk("prio_addr", imem_addr, 32'h200);
        step(); chk("prio_v", {31'b0, valid}, 32'h0);
        step(); chk("prio_pc", pc, 32'h200); chk("prio_inst", inst, 32'h10013);

        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h203;
        step(); redirect = 1'b0;
        #1 chk("rs_bubble_v", {31'b0, valid}, 32'h0); chk("rs_bubble_inst", inst, 32'h13);
        chk("rs_req", {31'b0, imem_req}, 32'h1); chk("rs_addr", imem_addr, 32'h200);
        step(); chk("rs_nostale", {31'b0, valid}, 32'h0);
        stall = 1'b0;
        step(); chk("rs_pc200", pc, 32'h200); chk("rs_v200", {31'b0, valid}, 32'h1);
        step(); chk("rs_pc204", pc, 32'h204); chk("rs_inst204", inst, 32'h10213);

        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        #1 chk("wrap_flush_req", {31'b0, imem_req}, 32'h0);
        step(); redirect = 1'b0;
        #1 chk("wrap_addr_hi", imem_addr, 32'hFFFF_FFFC); chk("wrap_req", {31'b0, imem_req}, 32'h1);
        step(); chk("wrap_addr0", imem_addr, 32'h0);
        step(); chk("wrap_pc_hi", pc, 32'hFFFF_FFFC); chk("wrap_inst_hi", inst, 32'hFFFF_FE13);
        step(); chk("wrap_pc0", pc, 32'h0); chk("wrap_inst0", inst, 32'h13);

        hold = 1'b1;
        step(); chk("mr_pc4", pc, 32'h4);
        step(); chk("mr_credit_req", {31'b0, imem_req}, 32'h0); chk("mr_pc_hold", pc, 32'h4);
        rst = 1'b0; hold = 1'b0;
        #1;
        chk("mr_pc", pc, 32'h0);
        chk("mr_inst", inst, 32'h13);
        chk("mr_valid", {31'b0, valid}, 32'h0);
        chk("mr_req", {31'b0, imem_req}, 32'h0);
        chk("mr_addr", imem_addr, 32'h0);
        @(negedge clk) rst = 1'b1;
        step(); chk("reboot_addr0", imem_addr, 32'h0); chk("reboot_req", {31'b0, imem_req}, 32'h1);
        step(); chk("reboot_addr4", imem_addr, 32'h4); chk("reboot_novalid", {31'b0, valid}, 32'h0);
        step(); chk("reboot_pc0", pc, 32'h0); chk("reboot_v", {31'b0, valid}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
